// File: rtl/aux_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aux_input_conditioner: 2-FF sync, tick-sampled debounce, rise/fall pulses |
// | Option: AUX_INPUT_REPEAT_EN adds auto-repeat rise pulses on held inputs   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module aux_input_conditioner #(
  parameter int InWidth     = 17,
  parameter int TickCnt     = 100000,
  parameter int StableTicks = 4,
  parameter int RepeatTicks = 250
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [InWidth-1:0] raw_in,
  output logic [InWidth-1:0] level,
  output logic [InWidth-1:0] rise,
  output logic [InWidth-1:0] fall,
  output logic               any_change
);

  localparam int c_tick_w = $clog2(TickCnt);
  localparam int c_cnt_w  = $clog2(StableTicks + 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TickCnt - 1);
`ifdef AUX_INPUT_REPEAT_EN
  localparam int c_hold_w = $clog2(RepeatTicks + 1);
`endif

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  logic [InWidth-1:0]  r_sync1;
  logic [InWidth-1:0]  r_sync2;
  logic [c_tick_w-1:0] r_tick_cnt;
  logic                w_tick;

  // Empty when the parameters are in range; keeps every parameter referenced.
  if (TickCnt < 2 || StableTicks < 1 || RepeatTicks < 1) begin : g_param_range_invalid
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == c_tick_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick_cnt <= '0;
    else        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
  end

  for (genvar gi = 0; gi < InWidth; gi++) begin : g_bit
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_level, w_level_nxt;
    logic               r_rise, w_rise_nxt;
    logic               r_fall, w_fall_nxt;
    logic               w_diff;
    logic               w_accept;
`ifdef AUX_INPUT_REPEAT_EN
    logic [c_hold_w-1:0] r_hold;
    logic [c_hold_w-1:0] w_hold_nxt;
`endif

    assign w_diff = r_sync2[gi] ^ r_level;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_STABLE: begin
            if (!w_diff) begin
              w_cnt_nxt = '0;
            end else if (StableTicks == 1) begin
              w_accept = 1'b1;
            end else begin
              w_state_nxt = ST_CHECK;
              w_cnt_nxt   = c_cnt_w'(1);
            end
          end
          ST_CHECK: begin
            if (!w_diff) begin
              w_state_nxt = ST_STABLE;
              w_cnt_nxt   = '0;
            end else if (int'(r_cnt) + 1 >= StableTicks) begin
              w_accept = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
      if (w_accept) begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    end

    always_comb begin
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      if (w_accept) begin
        w_level_nxt = r_sync2[gi];
        w_rise_nxt  = r_sync2[gi];
        w_fall_nxt  = ~r_sync2[gi];
      end
`ifdef AUX_INPUT_REPEAT_EN
      // Hold time restarts on any disagreement, so only an unbroken high run repeats.
      w_hold_nxt = r_hold;
      if (w_accept || (w_tick && w_diff) || !r_level) begin
        w_hold_nxt = '0;
      end else if (w_tick && r_state == ST_STABLE) begin
        if (int'(r_hold) + 1 >= RepeatTicks) begin
          w_hold_nxt = '0;
          w_rise_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
`ifdef AUX_INPUT_REPEAT_EN
        r_hold  <= '0;
`endif
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= w_level_nxt;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
`ifdef AUX_INPUT_REPEAT_EN
        r_hold  <= w_hold_nxt;
`endif
      end
    end

    assign level[gi] = r_level;
    assign rise[gi]  = r_rise;
    assign fall[gi]  = r_fall;
  end

  assign any_change = |(rise | fall);

endmodule
`default_nettype wire

// File: tb/tb_aux_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aux_input_conditioner: directed + random stimulus vs behavioural model |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_aux_input_conditioner;

  localparam int InWidth     = 17;
  localparam int TickCnt     = 4;
  localparam int StableTicks = 3;
  localparam int RepeatTicks = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [InWidth-1:0] raw_in = '0;
  logic [InWidth-1:0] level, rise, fall;
  logic               any_change;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  aux_input_conditioner #(
    .InWidth(InWidth), .TickCnt(TickCnt),
    .StableTicks(StableTicks), .RepeatTicks(RepeatTicks)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .level(level), .rise(rise), .fall(fall), .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a change is accepted once the last StableTicks tick samples taken
  // since the previous acceptance all disagree with the current level.
  logic [InWidth-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
  int                 m_tcnt;
  logic [15:0]        m_hist    [InWidth];
  int                 m_nsince  [InWidth];
  int                 m_hold    [InWidth];
  bit                 m_prevdiff[InWidth];

  always @(posedge clk or negedge rst_n) begin : model
    logic s;
    bit   run;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_tcnt = 0;
      for (int i = 0; i < InWidth; i++) begin
        m_hist[i] = '0; m_nsince[i] = 0; m_hold[i] = 0; m_prevdiff[i] = 1'b0;
      end
    end else begin
      m_rise = '0;
      m_fall = '0;
      if (m_tcnt == TickCnt - 1) begin
        for (int i = 0; i < InWidth; i++) begin
          s = m_s2[i];
          m_hist[i] = {m_hist[i][14:0], s};
          m_nsince[i]++;
          run = (m_nsince[i] >= StableTicks);
          for (int k = 0; k < StableTicks; k++)
            if (m_hist[i][k] == m_level[i]) run = 1'b0;
          if (run) begin
            m_level[i] = s;
            if (s) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            m_nsince[i] = 0; m_hold[i] = 0; m_prevdiff[i] = 1'b0;
          end else if (s != m_level[i]) begin
            m_hold[i] = 0; m_prevdiff[i] = 1'b1;
          end else begin
`ifdef AUX_INPUT_REPEAT_EN
            if (m_level[i] && !m_prevdiff[i]) begin
              m_hold[i]++;
              if (m_hold[i] == RepeatTicks) begin
                m_rise[i] = 1'b1;
                m_hold[i] = 0;
              end
            end
`endif
            m_prevdiff[i] = 1'b0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_in;
      m_tcnt = (m_tcnt == TickCnt - 1) ? 0 : m_tcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_level", 32'(level), 32'(m_level));
      check("cyc_rise",  32'(rise),  32'(m_rise));
      check("cyc_fall",  32'(fall),  32'(m_fall));
      check("cyc_any",   32'(any_change), 32'(|(m_rise | m_fall)));
    end
  end

  task automatic settle(input int n);
    raw_in = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt_r, cnt_f, cnt_ac, t_r, t_f, idx;

    repeat (3) @(negedge clk);
    check("reset_level", 32'(level), 32'd0);
    check("reset_rise",  32'(rise),  32'd0);
    check("reset_fall",  32'(fall),  32'd0);
    check("reset_any",   32'(any_change), 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // idle
    cnt_ac = 0;
    repeat (100) begin @(negedge clk); if (any_change) cnt_ac++; end
    check("idle_any_count", 32'(cnt_ac), 32'd0);
    check("idle_level", 32'(level), 32'd0);

    // clean rising edge latency
    raw_in[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rise[0] && n < 40);
    check("t2_rise_seen", 32'(rise[0]), 32'd1);
    check("t2_latency_in_range", 32'(n >= 11 && n <= 15), 32'd1);
    check("t2_level", 32'(level[0]), 32'd1);
    settle(30);

    // short pulse rejected
    raw_in[3] = 1'b1;
    repeat (6) @(negedge clk);
    raw_in[3] = 1'b0;
    cnt_r = 0;
    repeat (30) begin @(negedge clk); if (rise[3] || fall[3]) cnt_r++; end
    check("t3_no_pulse", 32'(cnt_r), 32'd0);
    check("t3_level", 32'(level[3]), 32'd0);

    // chatter then hold
    cnt_r = 0; cnt_f = 0;
    for (int c = 0; c < 30; c++) begin
      if (c % 3 == 0) raw_in[5] = ~raw_in[5];
      @(negedge clk);
      if (rise[5]) cnt_r++;
      if (fall[5]) cnt_f++;
    end
    raw_in[5] = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (rise[5]) cnt_r++;
      if (fall[5]) cnt_f++;
    end while (!rise[5] && n < 40);
    check("t4_one_rise", 32'(cnt_r), 32'd1);
    check("t4_no_fall", 32'(cnt_f), 32'd0);
    check("t4_level", 32'(level[5]), 32'd1);
    settle(30);

    // simultaneous opposite edges on two bits
    raw_in[2] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!level[2] && n < 40);
    check("t5_level2_set", 32'(level[2]), 32'd1);
    raw_in[1] = 1'b1;
    raw_in[2] = 1'b0;
    t_r = -1; t_f = -1; cnt_ac = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rise[1]) t_r = c;
      if (fall[2]) t_f = c;
      if (any_change) cnt_ac++;
    end
    check("t5_rise1_seen", 32'(t_r > 0), 32'd1);
    check("t5_same_cycle", 32'(t_r), 32'(t_f));
    check("t5_any_once", 32'(cnt_ac), 32'd1);
    settle(30);

    // async reset mid-debounce
    raw_in[7] = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_level", 32'(level), 32'd0);
    check("t6_async_rise",  32'(rise),  32'd0);
    check("t6_async_any",   32'(any_change), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rise[7] && n < 40);
    check("t6_rise_seen", 32'(rise[7]), 32'd1);
    check("t6_full_debounce", 32'(n >= 11 && n <= 15), 32'd1);
    settle(30);

    // random activity
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) begin
        idx = int'($urandom_range(InWidth - 1));
        raw_in[idx] = ~raw_in[idx];
      end
    end
    settle(40);

    // held button: auto-repeat or single rise
    raw_in[16] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rise[16] && n < 40);
    check("t7_first_rise", 32'(rise[16]), 32'd1);
`ifdef AUX_INPUT_REPEAT_EN
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!rise[16] && n < 40);
      check("t7_repeat_period", 32'(n), 32'd20);
    end
`else
    cnt_r = 0;
    repeat (100) begin @(negedge clk); if (rise[16]) cnt_r++; end
    check("t7_no_repeat", 32'(cnt_r), 32'd0);
`endif
    raw_in[16] = 1'b0;
    cnt_r = 0; cnt_f = 0;
    repeat (40) begin
      @(negedge clk);
      if (rise[16]) cnt_r++;
      if (fall[16]) cnt_f++;
    end
    check("t7_one_fall", 32'(cnt_f), 32'd1);
    check("t7_no_rise_after", 32'(cnt_r), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
